// File: rtl/videocard_pkg.sv
// Shared types and constants for the videocard host driver.
// States, the fixed control-port map and a width helper for the poll counter.
package videocard_pkg;

    // Driver sequencing states
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        POLL_REQ,
        POLL_WAIT,
        FINISH,
        READBACK,
        DONE
    } state_t;

    // Control-port register map of the videocard
    localparam logic        CTRL_ADDR_START   = 1'b0;
    localparam logic        CTRL_ADDR_STATUS  = 1'b1;
    localparam logic [7:0]  CTRL_CMD_START    = 8'h01;
    localparam int unsigned STATUS_FINISH_BIT = 0;

    // Bits needed to count 0..limit; a disabled limit (0) still gets one bit.
    function automatic int unsigned poll_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/videocard_addr_counter.sv
// Loadable wrapping word address paired with a down-counter of remaining words.
// Used once for the RAM load and once for the optional readback pass.
module videocard_addr_counter
    import videocard_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W-1:0] load_count,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] rem,
    output logic              zero
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rem_q;

    // Load takes priority; a step advances the address (wrapping) and consumes one word.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else if (load) begin
            addr_q <= load_addr;
            rem_q  <= load_count;
        end else if (step) begin
            addr_q <= addr_q + ADDR_W'(1);
            rem_q  <= rem_q - ADDR_W'(1);
        end
    end

    assign addr = addr_q;
    assign rem  = rem_q;
    assign zero = (rem_q == '0);

endmodule

// File: rtl/videocard_host_driver.sv
// Avalon-MM initiator that loads a word block into the videocard RAM, kicks the
// card through its control port and polls for the finish flag.
// Optional readback of a RAM window after completion: VIDEOCARD_HOST_DRIVER_READBACK_EN.
module videocard_host_driver
    import videocard_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned WIDTH_CTRL = 8,
    parameter int unsigned BYTES      = 4,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic                  clk,
    input  logic                  reset_sink_reset,
    input  logic                  cmd_start,
    input  logic [ADDR_W-1:0]     cmd_base,
    input  logic [ADDR_W-1:0]     cmd_count,
    output logic                  cmd_busy,
    output logic                  cmd_done,
    output logic                  cmd_error,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_W-1:0]     m_address,
    output logic [WIDTH-1:0]      m_writedata,
    output logic [BYTES-1:0]      m_byteenable,
    output logic                  m_write,
    output logic                  m_read,
    input  logic [WIDTH-1:0]      m_readdata,
    output logic                  c_address,
    output logic [WIDTH_CTRL-1:0] c_writedata,
    output logic                  c_write,
    output logic                  c_read,
    input  logic [WIDTH_CTRL-1:0] c_readdata
`ifdef VIDEOCARD_HOST_DRIVER_READBACK_EN
    ,
    input  logic [ADDR_W-1:0]     rd_base,
    input  logic [ADDR_W-1:0]     rd_count,
    output logic [WIDTH-1:0]      r_data,
    output logic                  r_valid,
    input  logic                  r_ready
`endif
);

    localparam int unsigned      POLL_W   = poll_width(POLL_LIMIT);
    localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(POLL_LIMIT);

    state_t            state_q, state_d;
    logic [POLL_W-1:0] polls_q, polls_d;
    logic              err_q, err_d;

    logic              start_ok;
    logic              ld_step;
    logic [ADDR_W-1:0] ld_addr;
    logic [ADDR_W-1:0] ld_rem;
    logic              ld_zero;

    // Only bit0 of the status word and (without readback) no read data are consumed.
    logic unused_inputs;
    assign unused_inputs = ^{m_readdata, c_readdata};

    assign start_ok = (state_q == IDLE) && cmd_start;

    videocard_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_load_ctr (
        .clk        (clk),
        .reset      (reset_sink_reset),
        .load       (start_ok),
        .load_addr  (cmd_base),
        .load_count (cmd_count),
        .step       (ld_step),
        .addr       (ld_addr),
        .rem        (ld_rem),
        .zero       (ld_zero)
    );

`ifdef VIDEOCARD_HOST_DRIVER_READBACK_EN
    logic              rb_step;
    logic [ADDR_W-1:0] rb_addr;
    logic [ADDR_W-1:0] rb_rem;
    logic              rb_zero;
    logic              rd_pend_q, rd_pend_d;
    logic              r_valid_q, r_valid_d;
    logic [WIDTH-1:0]  r_data_q, r_data_d;

    // Remaining-count value itself is only needed through the zero flag.
    logic unused_rb_rem;
    assign unused_rb_rem = ^rb_rem;

    videocard_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_rb_ctr (
        .clk        (clk),
        .reset      (reset_sink_reset),
        .load       (start_ok),
        .load_addr  (rd_base),
        .load_count (rd_count),
        .step       (rb_step),
        .addr       (rb_addr),
        .rem        (rb_rem),
        .zero       (rb_zero)
    );

    // Read data is presented straight from the bus in the response cycle, then held.
    assign r_valid = rd_pend_q | r_valid_q;
    assign r_data  = rd_pend_q ? m_readdata : r_data_q;

    // Readback response/holding registers
    always_ff @(posedge clk) begin
        if (reset_sink_reset) begin
            rd_pend_q <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
        end
    end
`endif

    // State, poll counter and error flag registers
    always_ff @(posedge clk) begin
        if (reset_sink_reset) begin
            state_q <= IDLE;
            polls_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            polls_q <= polls_d;
            err_q   <= err_d;
        end
    end

    // Next-state and bus strobes; every strobe defaults low so at most one fires per state
    always_comb begin
        state_d      = state_q;
        polls_d      = polls_q;
        err_d        = err_q;
        cmd_busy     = (state_q != IDLE);
        cmd_done     = 1'b0;
        cmd_error    = 1'b0;
        s_ready      = 1'b0;
        m_address    = '0;
        m_writedata  = '0;
        m_byteenable = '0;
        m_write      = 1'b0;
        m_read       = 1'b0;
        c_address    = 1'b0;
        c_writedata  = '0;
        c_write      = 1'b0;
        c_read       = 1'b0;
        ld_step      = 1'b0;
`ifdef VIDEOCARD_HOST_DRIVER_READBACK_EN
        rb_step      = 1'b0;
        rd_pend_d    = rd_pend_q;
        r_valid_d    = r_valid_q;
        r_data_d     = r_data_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    err_d   = 1'b0;
                    state_d = (cmd_count == '0) ? KICK : LOAD;
                end
            end
            LOAD: begin
                if (ld_zero) begin
                    state_d = KICK;
                end else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        m_write      = 1'b1;
                        m_address    = ld_addr;
                        m_writedata  = s_data;
                        m_byteenable = '1;
                        ld_step      = 1'b1;
                        if (ld_rem == ADDR_W'(1)) begin
                            state_d = KICK;
                        end
                    end
                end
            end
            KICK: begin
                c_write     = 1'b1;
                c_address   = CTRL_ADDR_START;
                c_writedata = WIDTH_CTRL'(CTRL_CMD_START);
                polls_d     = '0;
                state_d     = POLL_REQ;
            end
            POLL_REQ: begin
                c_read    = 1'b1;
                c_address = CTRL_ADDR_STATUS;
                state_d   = POLL_WAIT;
            end
            POLL_WAIT: begin
                if (c_readdata[STATUS_FINISH_BIT]) begin
                    state_d = FINISH;
                end else if ((POLL_LIMIT != 0) && (polls_q == POLL_MAX)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    polls_d = polls_q + POLL_W'(1);
                    state_d = POLL_REQ;
                end
            end
            FINISH: begin
`ifdef VIDEOCARD_HOST_DRIVER_READBACK_EN
                state_d = rb_zero ? DONE : READBACK;
`else
                state_d = DONE;
`endif
            end
            READBACK: begin
`ifdef VIDEOCARD_HOST_DRIVER_READBACK_EN
                if (rd_pend_q || r_valid_q) begin
                    if (r_ready) begin
                        rd_pend_d = 1'b0;
                        r_valid_d = 1'b0;
                        if (rb_zero) begin
                            state_d = DONE;
                        end
                    end else if (rd_pend_q) begin
                        // Consumer stalled: capture the one-cycle bus data and hold it.
                        rd_pend_d = 1'b0;
                        r_valid_d = 1'b1;
                        r_data_d  = m_readdata;
                    end
                end else begin
                    m_read       = 1'b1;
                    m_address    = rb_addr;
                    m_byteenable = '1;
                    rb_step      = 1'b1;
                    rd_pend_d    = 1'b1;
                end
`else
                state_d = DONE;
`endif
            end
            DONE: begin
                cmd_done  = 1'b1;
                cmd_error = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/videocard_host_driver.md
Name: videocard_host_driver

Overview:
- Single-clock Avalon-MM initiator that drives the videocard from the HPS side.
- Streams a block of 32-bit words into the videocard shared RAM through its data port.
- Writes the start command through the 8-bit control port, then polls the control port until the finish flag is seen.
- Sits in fabric between an HPS-fed stream source and the videocard's two slave ports, replacing software polling.

Parameters:
- WIDTH, 32, data port word width.
- WIDTH_CTRL, 8, control port data width.
- BYTES, 4, data port byteenable width (WIDTH/8).
- ADDR_W, 16, data port word address width.
- POLL_LIMIT, 1024, maximum control reads before timeout; 0 disables the timeout.

Ports:
- clk  in  1  sole clock.
- reset_sink_reset  in  1  synchronous, active-high reset.
- cmd_start  in  1  one-cycle request; sampled only in IDLE.
- cmd_base  in  ADDR_W  first RAM word address.
- cmd_count  in  ADDR_W  number of words to load; 0 skips the load.
- cmd_busy  out  1  high in every state except IDLE.
- cmd_done  out  1  one-cycle pulse on completion.
- cmd_error  out  1  qualified by cmd_done: 1 = poll timeout.
- s_data  in  WIDTH  input stream data.
- s_valid  in  1  input stream valid.
- s_ready  out  1  input stream ready.
- m_address  out  ADDR_W  data port address.
- m_writedata  out  WIDTH  data port write data.
- m_byteenable  out  BYTES  data port byte enables.
- m_write  out  1  data port write strobe.
- m_read  out  1  data port read strobe.
- m_readdata  in  WIDTH  data port read data; valid exactly 1 cycle after m_read.
- c_address  out  1  control port address.
- c_writedata  out  WIDTH_CTRL  control port write data.
- c_write  out  1  control port write strobe.
- c_read  out  1  control port read strobe.
- c_readdata  in  WIDTH_CTRL  control port read data; valid 1 cycle after c_read.

Behaviour:
- Reset: all outputs 0, state IDLE, counters cleared. Reset asserted mid-operation aborts immediately; no cmd_done is issued.
- Control map (fixed):
  - address 0, write 8'h01 = start.
  - address 1, read bit0 = finish flag (responder clears it on read).
- IDLE:
  - On cmd_start, latch base and count into addr_q and rem_q.
  - rem_q==0 → KICK; otherwise → LOAD.
- LOAD:
  - s_ready = 1.
  - On s_valid & s_ready:
    - m_write = 1, m_address = addr_q, m_writedata = s_data, m_byteenable = all ones.
    - addr_q++, wrapping modulo 2^ADDR_W.
    - rem_q--.
  - After the last word → KICK.
  - No write strobe when s_valid = 0.
  - Throughput: 1 word per cycle.
- KICK:
  - One cycle with c_write = 1, c_address = 0, c_writedata = 8'h01.
  - → POLL_REQ; poll counter cleared.
- POLL_REQ: one cycle with c_read = 1, c_address = 1; → POLL_WAIT.
- POLL_WAIT: sample c_readdata.
  - bit0 = 1 → FINISH.
  - bit0 = 0 and POLL_LIMIT != 0 and polls == POLL_LIMIT → DONE with error set.
  - Otherwise polls++ and → POLL_REQ.
  - Poll rate: one read per 2 cycles.
- FINISH: → READBACK if the macro is defined, otherwise → DONE.
- DONE: cmd_done = 1 for one cycle, cmd_error valid in that cycle; → IDLE.
- cmd_start outside IDLE is ignored.
- Strobe exclusivity: m_write, m_read, c_write and c_read are never asserted in the same cycle.
- Latency: cmd_start to first m_write is 1 cycle.

Optional Feature:
- Macro: VIDEOCARD_HOST_DRIVER_READBACK_EN.
- When defined, additional ports:
  - rd_base in ADDR_W
  - rd_count in ADDR_W
  - r_data out WIDTH
  - r_valid out 1
  - r_ready in 1
- rd_base and rd_count are latched together with cmd_start.
- READBACK state:
  - Issue m_read at the current read address.
  - Present m_readdata on r_data with r_valid the next cycle.
  - Hold r_data/r_valid until r_ready; only then issue the next read.
  - Read address wraps like the load address.
  - rd_count = 0 skips READBACK.
- Timeout path (error) skips READBACK.
- When not defined: no extra ports; FINISH goes directly to DONE.

Decomposition:
- Shared package videocard_pkg:
  - state enum (IDLE, LOAD, KICK, POLL_REQ, POLL_WAIT, FINISH, READBACK, DONE).
  - CTRL_ADDR_START = 1'b0, CTRL_ADDR_STATUS = 1'b1, CTRL_CMD_START = 8'h01, STATUS_FINISH_BIT = 0.
- One natural sub-module: videocard_addr_counter (loadable wrapping address plus down-counter with zero flag), instantiated for load and for readback.

Test Plan:
- cmd_base = 16'h0010, cmd_count = 4, stream 32'hA0..A3 back-to-back → m_write on 4 consecutive cycles at addresses 0x10..0x13 with matching data, then c_write at addr 0 with data 0x01, then c_read at addr 1.
- cmd_count = 3 with s_valid gapped (1,0,0,1,1) → exactly 3 writes, no strobe in gap cycles, addresses contiguous.
- Status returns bit0 = 0 for 5 polls then 1 → 6 c_read strobes spaced 2 cycles apart, then cmd_done = 1 with cmd_error = 0.
- POLL_LIMIT = 8, status never sets → cmd_done with cmd_error = 1 after 9 reads; cmd_base = 16'hFFFE with cmd_count = 3 → write addresses FFFE, FFFF, 0000.
- Reset asserted during LOAD after 2 of 4 words → next-cycle outputs all 0, no cmd_done; a new cmd_start afterwards runs cleanly.
- With the readback macro: rd_count = 2, r_ready low for 3 cycles → r_data held stable, second m_read issued only after the handshake.
